uart_rx_word: RTL



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_byte.sv | 174 +++++++++++++++++
 rtl/uart_rx_word.sv | 116 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared state encoding and oversampling constants for the UART word receiver.
// Defining UART_RX_PARITY_EN adds the PARITY state used by the even-parity build.
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int SAMPLE_MID = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_t;

   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 16x oversampling 8N1 byte receiver: synchronizer, tick prescaler, bit FSM with 2-of-3 voting.
// UART_RX_PARITY_EN inserts an even-parity bit check and the parity_err pulse.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 12000000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_strobe,
   output logic       frame_err,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       busy
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [3:0] S_LO  = 4'(SAMPLE_MID - 1);
   localparam logic [3:0] S_MID = 4'(SAMPLE_MID);
   localparam logic [3:0] S_HI  = 4'(SAMPLE_MID + 1);
   localparam logic [3:0] S_END = 4'(OVERSAMPLE - 1);

   logic          rx_m_reg, rx_s_reg;
   logic [PW-1:0] presc_reg;
   logic          tick;
   rx_state_t     state_reg, state_next;
   logic [3:0]    samp_reg, samp_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    shift_reg, shift_next;
   logic [1:0]    ones_reg, ones_next;
   logic          bad_reg, bad_next;
   logic          strobe_reg, strobe_next;
   logic          ferr_reg, ferr_next;
   logic          maj;
`ifdef UART_RX_PARITY_EN
   logic          perr_reg, perr_next;
`endif

   assign tick = (presc_reg == PW'(DIV - 1));
   // Votes from samples 7 and 8 are banked; sample 9 completes the majority.
   assign maj  = (ones_reg == 2'd2) || ((ones_reg == 2'd1) && rx_s_reg);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_m_reg   <= 1'b1;
         rx_s_reg   <= 1'b1;
         presc_reg  <= '0;
         state_reg  <= ST_IDLE;
         samp_reg   <= '0;
         bit_reg    <= '0;
         shift_reg  <= '0;
         ones_reg   <= '0;
         bad_reg    <= 1'b0;
         strobe_reg <= 1'b0;
         ferr_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_reg   <= 1'b0;
`endif
      end else begin
         rx_m_reg   <= rx;
         rx_s_reg   <= rx_m_reg;
         presc_reg  <= tick ? '0 : presc_reg + 1'b1;
         state_reg  <= state_next;
         samp_reg   <= samp_next;
         bit_reg    <= bit_next;
         shift_reg  <= shift_next;
         ones_reg   <= ones_next;
         bad_reg    <= bad_next;
         strobe_reg <= strobe_next;
         ferr_reg   <= ferr_next;
`ifdef UART_RX_PARITY_EN
         perr_reg   <= perr_next;
`endif
      end
   end

   always_comb begin
      state_next  = state_reg;
      samp_next   = samp_reg;
      bit_next    = bit_reg;
      shift_next  = shift_reg;
      ones_next   = ones_reg;
      bad_next    = bad_reg;
      strobe_next = 1'b0;
      ferr_next   = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_next   = 1'b0;
`endif
      if (tick) begin
         samp_next = samp_reg + 4'd1;
         if (samp_reg == S_LO || samp_reg == S_MID)
            ones_next = ones_reg + {1'b0, rx_s_reg};
         unique case (state_reg)
            ST_IDLE: begin
               samp_next = '0;
               ones_next = '0;
               if (!rx_s_reg) state_next = ST_START;
            end
            // Start bit is confirmed mid-bit but held until its end so data counts align to bit edges.
            ST_START: begin
               if (samp_reg == S_LO && rx_s_reg) begin
                  state_next = ST_IDLE;
               end else if (samp_reg == S_END) begin
                  state_next = ST_DATA;
                  samp_next  = '0;
                  ones_next  = '0;
                  bit_next   = '0;
                  bad_next   = 1'b0;
               end
            end
            ST_DATA: begin
               if (samp_reg == S_HI) shift_next = {maj, shift_reg[7:1]};
               if (samp_reg == S_END) begin
                  samp_next = '0;
                  ones_next = '0;
                  bit_next  = bit_reg + 3'd1;
                  if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_next = ST_PARITY;
`else
                     state_next = ST_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (samp_reg == S_HI && ((^shift_reg) ^ maj)) begin
                  perr_next = 1'b1;
                  bad_next  = 1'b1;
               end
               if (samp_reg == S_END) begin
                  state_next = ST_STOP;
                  samp_next  = '0;
                  ones_next  = '0;
               end
            end
`endif
            ST_STOP: begin
               if (samp_reg == S_HI) begin
                  samp_next = '0;
                  ones_next = '0;
                  if (maj) begin
                     strobe_next = !bad_reg;
                     state_next  = ST_IDLE;
                  end else begin
                     ferr_next  = 1'b1;
                     state_next = ST_WAIT_HIGH;
                  end
               end
            end
            ST_WAIT_HIGH: begin
               samp_next = '0;
               if (rx_s_reg) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   assign byte_data   = shift_reg;
   assign byte_strobe = strobe_reg;
   assign frame_err   = ferr_reg;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = perr_reg;
`endif
   assign busy        = (state_reg != ST_IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// Packs BYTES received bytes (first byte in the MSBs) into a word with a valid/ready output.
// UART_RX_PARITY_EN exposes parity_err and treats a parity failure like a framing failure.
module uart_rx_word
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 12000000,
   parameter int BAUD     = 9600,
   parameter int BYTES    = 4
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               rx,
   output logic [8*BYTES-1:0] word_data,
   output logic               word_valid,
   input  logic               word_ready,
   output logic               byte_strobe,
   output logic               frame_err,
   output logic               overrun,
`ifdef UART_RX_PARITY_EN
   output logic               parity_err,
`endif
   output logic               busy
);

   localparam int WW = 8 * BYTES;
   localparam int AW = (BYTES > 1) ? 8 * (BYTES - 1) : 1;
   localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [7:0]    rx_byte;
   logic          rx_strobe, rx_ferr, drop;
   logic [AW-1:0] acc_reg, acc_next, acc_shift;
   logic [WW-1:0] word_new, data_reg, data_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          valid_reg, valid_next;
   logic          ovr_reg, ovr_next;

   uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_byte (
      .clk         (clk),
      .nrst        (nrst),
      .rx          (rx),
      .byte_data   (rx_byte),
      .byte_strobe (rx_strobe),
      .frame_err   (rx_ferr),
`ifdef UART_RX_PARITY_EN
      .parity_err  (parity_err),
`endif
      .busy        (busy)
   );

`ifdef UART_RX_PARITY_EN
   assign drop = rx_ferr | parity_err;
`else
   assign drop = rx_ferr;
`endif

   // The accumulator only needs the BYTES-1 bytes that precede the completing one.
   generate
      if (BYTES == 1) begin : g_one
         assign word_new  = rx_byte;
         assign acc_shift = acc_reg;
      end else begin : g_multi
         assign word_new  = {acc_reg, rx_byte};
         assign acc_shift = word_new[AW-1:0];
      end
   endgenerate

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         acc_reg   <= '0;
         cnt_reg   <= '0;
         data_reg  <= '0;
         valid_reg <= 1'b0;
         ovr_reg   <= 1'b0;
      end else begin
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         data_reg  <= data_next;
         valid_reg <= valid_next;
         ovr_reg   <= ovr_next;
      end
   end

   always_comb begin
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      data_next  = data_reg;
      valid_next = valid_reg;
      ovr_next   = 1'b0;
      if (valid_reg && word_ready) valid_next = 1'b0;
      if (drop) begin
         acc_next = '0;
         cnt_next = '0;
      end else if (rx_strobe) begin
         acc_next = acc_shift;
         if (cnt_reg == CW'(BYTES - 1)) begin
            cnt_next = '0;
            // A word still waiting downstream wins; the new one is dropped.
            if (!valid_reg || word_ready) begin
               data_next  = word_new;
               valid_next = 1'b1;
            end else begin
               ovr_next = 1'b1;
            end
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
   end

   assign word_data   = data_reg;
   assign word_valid  = valid_reg;
   assign byte_strobe = rx_strobe;
   assign frame_err   = rx_ferr;
   assign overrun     = ovr_reg;

endmodule
